// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared sizing constants for the single-clock FIFO         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifo_pkg;

    localparam int FIFO_DSIZE = 8;
    localparam int FIFO_ASIZE = 4;
    localparam int FIFO_DEPTH = 2 ** FIFO_ASIZE;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem : 2**ASIZE x DSIZE array, sync write, combinational read    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE,
    parameter int ASIZE = FIFO_ASIZE
) (
    input  logic             wclk,
    input  logic             wclken,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    // Storage is intentionally left unreset; the pointers define validity.
    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge wclk) begin
        if (wclken) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_ctrl : single-clock first-word-fall-through FIFO           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE,
    parameter int ASIZE = FIFO_ASIZE
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty
);

    localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic           wfull_q, wfull_d;
    logic           rempty_q, rempty_d;
    logic           push;
    logic           pop;

    always_comb begin
        push     = winc & ~wfull_q;
        pop      = rinc & ~rempty_q;
        wptr_d   = push ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d   = pop  ? (rptr_q + PTR_ONE) : rptr_q;
        // Flags look at next-state pointers so they move on the causing edge.
        rempty_d = (rptr_d == wptr_d);
        wfull_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
                   (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
        end
    end

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_fifo_mem (
        .wclk   (wclk),
        .wclken (push & wrst_n),
        .waddr  (wptr_q[ASIZE-1:0]),
        .wdata  (wdata),
        .raddr  (rptr_q[ASIZE-1:0]),
        .rdata  (rdata)
    );

    assign wfull  = wfull_q;
    assign rempty = rempty_q;

endmodule : sync_fifo_ctrl
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_fifo_ctrl : vector table plus directed corner sequences      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sync_fifo_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] rdata;
    logic       wfull;
    logic       rempty;

    int checks = 0;
    int failures = 0;

    sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .wdata  (wdata),
        .winc   (winc),
        .rinc   (rinc),
        .rdata  (rdata),
        .wfull  (wfull),
        .rempty (rempty)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       rst_n;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic       e_empty;
        logic       e_full;
        logic       chk_data;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
        wrst_n = r;
        winc   = w;
        rinc   = rd;
        wdata  = d;
        @(posedge wclk);
        #1;
    endtask

    task automatic flags(input string name, input logic e_empty, input logic e_full);
        check({name, ".rempty"}, int'(rempty), int'(e_empty));
        check({name, ".wfull"}, int'(wfull), int'(e_full));
    endtask

    task automatic add_vec(input logic r, input logic w, input logic rd, input logic [7:0] d,
                           input logic ee, input logic ef, input logic cd, input logic [7:0] ed);
        vec_t v;
        v.rst_n = r; v.wr = w; v.rd = rd; v.din = d;
        v.e_empty = ee; v.e_full = ef; v.chk_data = cd; v.e_data = ed;
        vecs.push_back(v);
    endtask

    initial begin
        // Reset held two edges with writes requested, then read on empty.
        add_vec(1'b0, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00);
        add_vec(1'b0, 1'b1, 1'b0, 8'h98, 1'b1, 1'b0, 1'b0, 8'h00);
        add_vec(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
        // Ordered writes 5..40: head stays at 5.
        for (int i = 0; i < 8; i++)
            add_vec(1'b1, 1'b1, 1'b0, 8'(5 * (i + 1)), 1'b0, 1'b0, 1'b1, 8'd5);
        // Continuous pops: head advances, empty on the edge that pops 40.
        for (int i = 0; i < 7; i++)
            add_vec(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'(5 * (i + 2)));
        add_vec(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);

        foreach (vecs[k]) begin
            step(vecs[k].rst_n, vecs[k].wr, vecs[k].rd, vecs[k].din);
            flags($sformatf("vec%0d", k), vecs[k].e_empty, vecs[k].e_full);
            if (vecs[k].chk_data)
                check($sformatf("vec%0d.rdata", k), int'(rdata), int'(vecs[k].e_data));
        end

        // Fill to full with 0x01..0x10.
        for (int j = 1; j <= 16; j++) begin
            step(1'b1, 1'b1, 1'b0, 8'(j));
            flags($sformatf("fill%0d", j), 1'b0, (j == 16));
            check($sformatf("fill%0d.rdata", j), int'(rdata), 1);
        end
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        flags("write_when_full", 1'b0, 1'b1);
        check("write_when_full.rdata", int'(rdata), 1);

        // Simultaneous on full: only the pop happens.
        step(1'b1, 1'b1, 1'b1, 8'hAA);
        flags("simul_full", 1'b0, 1'b0);
        check("simul_full.rdata", int'(rdata), 2);
        for (int k = 2; k <= 16; k++) begin
            check($sformatf("drain_full%0d.rdata", k), int'(rdata), k);
            step(1'b1, 1'b0, 1'b1, 8'h00);
        end
        flags("drain_full_end", 1'b1, 1'b0);

        // Simultaneous on empty: only the write happens.
        step(1'b1, 1'b1, 1'b1, 8'h55);
        flags("simul_empty", 1'b0, 1'b0);
        check("simul_empty.rdata", int'(rdata), 'h55);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        flags("simul_empty_pop", 1'b1, 1'b0);

        // Streaming across pointer wrap after 4-word prefill.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b0, 8'(i * 3));
        for (int i = 0; i < 40; i++) begin
            check($sformatf("stream%0d.rdata", i), int'(rdata), (i * 3) % 256);
            step(1'b1, 1'b1, 1'b1, 8'((i + 4) * 3));
            flags($sformatf("stream%0d", i), 1'b0, 1'b0);
        end
        for (int i = 40; i < 44; i++) begin
            check($sformatf("stream_drain%0d.rdata", i), int'(rdata), (i * 3) % 256);
            step(1'b1, 1'b0, 1'b1, 8'h00);
        end
        flags("stream_end", 1'b1, 1'b0);

        // Mid-operation reset discards 6 stored words.
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
        flags("pre_reset", 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        flags("mid_reset", 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h77);
        flags("post_reset_write", 1'b0, 1'b0);
        check("post_reset_write.rdata", int'(rdata), 'h77);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        flags("post_reset_pop", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_fifo_ctrl
`default_nettype wire
